// File: rtl/mutex_rr_arbiter.sv
// Round-robin mutual-exclusion arbiter: at most one grant, held while the holder's req stays high.
// Define MUTEX_ARB_TIMEOUT_EN to add the hold-timeout with requester lockout.
module mutex_rr_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner,
  output logic                 timeout
);

  // state  | meaning
  // S_IDLE | no grant; arbitrate from ptr on the next edge
  // S_HOLD | one grant active, owned by owner_q
  localparam int OW = $clog2(N);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  if (N < 2 || N > 8 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_param_check
    $error("mutex_rr_arbiter: parameter out of range");
  end

  state_t          state_q;
  logic [N-1:0]    gnt_q;
  logic            busy_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   ptr_q;

  logic [N-1:0]    elig_d;
  logic            pick_found_d;
  logic [OW-1:0]   pick_idx_d;
  logic [OW-1:0]   scan_d;
  logic [OW-1:0]   ptr_adv_d;
  logic            holder_req_d;

`ifdef MUTEX_ARB_TIMEOUT_EN
  logic [7:0]      hold_cnt_q;
  logic [N-1:0]    lock_q;
  logic            timeout_q;

  assign elig_d  = req & ~lock_q;
  assign timeout = timeout_q;
`else
  assign elig_d  = req;
  assign timeout = 1'b0;
`endif

  assign gnt          = gnt_q;
  assign busy         = busy_q;
  assign owner        = owner_q;
  assign holder_req_d = req[owner_q];
  assign ptr_adv_d    = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

  // First eligible requester scanning upward from ptr, wrapping at N-1.
  always_comb begin
    pick_found_d = 1'b0;
    pick_idx_d   = '0;
    scan_d       = '0;
    for (int k = 0; k < N; k++) begin
      scan_d = OW'((int'(ptr_q) + k) % N);
      if (!pick_found_d && elig_d[scan_d]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = scan_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
      ptr_q      <= '0;
`ifdef MUTEX_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      lock_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef MUTEX_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
      // A locked-out requester is released once its req is seen low.
      lock_q    <= lock_q & req;
`endif
      case (state_q)
        S_IDLE: begin
          if (pick_found_d) begin
            state_q    <= S_HOLD;
            gnt_q      <= {{(N-1){1'b0}}, 1'b1} << pick_idx_d;
            busy_q     <= 1'b1;
            owner_q    <= pick_idx_d;
`ifdef MUTEX_ARB_TIMEOUT_EN
            hold_cnt_q <= 8'(HOLD_MAX - 1);
`endif
          end
        end
        S_HOLD: begin
          if (!holder_req_d) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= ptr_adv_d;
`ifdef MUTEX_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == '0) begin
            state_q         <= S_IDLE;
            gnt_q           <= '0;
            busy_q          <= 1'b0;
            owner_q         <= '0;
            ptr_q           <= ptr_adv_d;
            timeout_q       <= 1'b1;
            lock_q[owner_q] <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          owner_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mutex_rr_arbiter.sv
// Scoreboard bench for mutex_rr_arbiter: a cycle model pushes expected outputs as req is driven,
// popped and compared one edge later. Honours MUTEX_ARB_TIMEOUT_EN (HOLD_MAX = 4).
module tb_mutex_rr_arbiter;
  localparam int N  = 4;
  localparam int HM = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         busy;
  logic [1:0]   owner;
  logic         timeout;

  mutex_rr_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .busy(busy), .owner(owner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         busy;
    logic [1:0]   owner;
    logic         timeout;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   to_seen;

  int           m_busy, m_owner, m_ptr, m_held;
  logic [N-1:0] m_lock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_lock = '0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [N-1:0] r, output exp_t e);
    logic [N-1:0] elig;
    int pick, idx;
    e.timeout = 1'b0;
`ifdef MUTEX_ARB_TIMEOUT_EN
    elig   = r & ~m_lock;
    m_lock = m_lock & r;
`else
    elig   = r;
`endif
    if (m_busy == 0) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (pick < 0 && elig[idx[1:0]]) pick = idx;
      end
      if (pick >= 0) begin
        m_busy = 1; m_owner = pick; m_held = 1;
      end
    end else if (!r[m_owner[1:0]]) begin
      m_ptr = (m_owner + 1) % N; m_busy = 0; m_owner = 0;
    end
`ifdef MUTEX_ARB_TIMEOUT_EN
    else if (m_held == HM) begin
      m_lock[m_owner[1:0]] = 1'b1;
      m_ptr = (m_owner + 1) % N; m_busy = 0; m_owner = 0;
      e.timeout = 1'b1;
    end
`endif
    else m_held++;
    e.gnt   = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.busy  = (m_busy != 0);
    e.owner = m_owner[1:0];
  endtask

  // Drive req one cycle, then compare the outputs registered on that edge.
  task automatic step(input logic [N-1:0] r);
    exp_t e;
    req = r;
    model_step(r, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("gnt",     32'(gnt),     32'(e.gnt));
    check("busy",    32'(busy),    32'(e.busy));
    check("owner",   32'(owner),   32'(e.owner));
    check("timeout", 32'(timeout), 32'(e.timeout));
    check("onehot",  32'($countones(gnt) <= 1), 32'd1);
    if (timeout) to_seen++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_gnt",     32'(gnt),     32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_owner",   32'(owner),   32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    to_seen = 0;
    model_reset();
    #3;

    // Single request and release
    apply_reset();
    step(4'b0001);
    check("single_gnt", 32'(gnt), 32'h1);
    step(4'b0000);
    step(4'b0000);

    // Holder dropping in its grant cycle still sees one grant cycle
    step(4'b0010);
    step(4'b0000);
    step(4'b0000);

    // All requesting: rotation 0,1,2,3,0 with an idle cycle between grants
    apply_reset();
    for (int g = 0; g < 5; g++) begin
      step(4'b1111);
      check("rr_order", 32'(owner), 32'(g % N));
      step(4'b1111);
      step(4'b1111);
      step(4'b1111 & ~(4'b0001 << (g % N)));
    end

    // Requester 2 holds while req[0] and req[3] toggle
    apply_reset();
    step(4'b0100);
    for (int i = 0; i < 10; i++)
      step(((i % 2) == 0) ? 4'b1101 : 4'b0100);
    step(4'b1001);
    step(4'b1001);

    // Asynchronous reset in the middle of a hold
    apply_reset();
    step(4'b0010);
    step(4'b0010);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_gnt",  32'(gnt),  32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    model_reset();
    step(4'b1010);
    check("rst_restart", 32'(gnt), 32'h2);

    // Long hold: times out when the feature is built in, held forever otherwise
    apply_reset();
    to_seen = 0;
    for (int i = 0; i < 100; i++) step(4'b0001);
`ifdef MUTEX_ARB_TIMEOUT_EN
    check("timeout_pulses", 32'(to_seen), 32'd1);
`else
    check("timeout_pulses", 32'(to_seen), 32'd0);
`endif
    step(4'b0000);
    step(4'b0001);
    step(4'b0001);
    step(4'b0000);

    // Random traffic against the model
    apply_reset();
    for (int i = 0; i < 300; i++) step(4'($urandom_range(0, 15)));
    step(4'b0000);
    step(4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
